seq_mult_param: RTL and testbench



---
 rtl/seq_mult_param_pkg.sv | 9 +
 rtl/seq_mult_param_if.sv | 12 +
 rtl/seq_mult_param_ctrl.sv | 62 ++++++
 rtl/seq_mult_param.sv | 65 ++++++
 tb/tb_seq_mult_param.sv | 126 ++++++++++++
 5 files changed

// File: rtl/seq_mult_param_pkg.sv
// seq_mult_pkg: shared state encoding, default width and operand magnitude helper
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int MAX_WIDTH = 64;
  function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic [MAX_WIDTH-1:0] value, input int width, input logic signed_mode);
    return (signed_mode && value[width-1]) ? -value : value;
  endfunction
endpackage

// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: start/done command bus between a sequencer and the multiplier
interface seq_mult_param_if #(parameter int WIDTH = seq_mult_pkg::DEF_WIDTH);
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  modport master(output start, signed_mode, a, b, input busy, done, product);
  modport slave(input start, signed_mode, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_param_ctrl.sv
// seq_mult_ctrl: IDLE/RUN/DONE sequencing and iteration counter (early exit under SEQ_MULT_EARLY_TERM_EN)
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef SEQ_MULT_EARLY_TERM_EN
  input  logic early,
  output logic [CNT_W-1:0] cnt,
`endif
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic finish
);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last;
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(1)) || early;
`else
  assign last = cnt_q == CNT_W'(1);
`endif
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = CNT_W'(WIDTH);
        load    = 1'b1;
      end
      RUN: begin
        step    = 1'b1;
        finish  = last;
        cnt_d   = last ? '0 : cnt_q - 1'b1;
        state_d = last ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add signed/unsigned multiplier datapath (early exit under SEQ_MULT_EARLY_TERM_EN)
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  seq_mult_param_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic load, step, finish, neg, busy, done;
  logic [WIDTH-1:0] mcand, mult;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] acc, acc_next, res, product;
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{mult[0]}}};
  assign acc_next = {sum, acc[WIDTH-1:1]};
`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] cnt;
  logic early;
  assign early = ~|mult[WIDTH-1:1];
  // skipped iterations would only have shifted, so apply them in one go
  assign res = acc_next >> (cnt - CNT_W'(1));
`else
  assign res = acc_next;
`endif
  seq_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .start(bus.start),
`ifdef SEQ_MULT_EARLY_TERM_EN
    .early(early),
    .cnt(cnt),
`endif
    .busy(busy),
    .done(done),
    .load(load),
    .step(step),
    .finish(finish)
  );
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mult    <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (load) begin
        mcand <= WIDTH'(abs_mag(MAX_WIDTH'(bus.a), WIDTH, bus.signed_mode));
        mult  <= WIDTH'(abs_mag(MAX_WIDTH'(bus.b), WIDTH, bus.signed_mode));
        acc   <= '0;
        neg   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end
      if (step) begin
        acc  <= acc_next;
        mult <= mult >> 1;
      end
      if (finish) product <= neg ? -res : res;
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed plus random checks of seq_mult_param against an arithmetic model
module tb_seq_mult_param;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  seq_mult_param_if #(.WIDTH(W)) bus ();
  seq_mult_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  function automatic longint operand(input logic sm, input logic [W-1:0] v);
    return sm ? longint'($signed(v)) : longint'(v);
  endfunction
  function automatic logic [2*W-1:0] model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p = operand(sm, a) * operand(sm, b);
    return p[2*W-1:0];
  endfunction
  function automatic int iters(input logic sm, input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    longint y = operand(sm, b);
    int n = 1;
    if (y < 0) y = -y;
    for (int i = 0; i < W + 1; i++) if (y[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction
  task automatic randomize_inputs();
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask
  task automatic run_op(input string tag, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [2*W-1:0] exp = model(sm, a, b);
    int n_exp = iters(sm, b);
    int n = 0;
    int busy_n = 0;
    bit got = 0;
    bus.start = 1'b1;
    bus.signed_mode = sm;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.start = noise;
    if (noise) randomize_inputs();
    while (!got && n < 40) begin
      if (bus.done) got = 1;
      else begin
        if (bus.busy) busy_n++;
        @(posedge clk); #1;
        n++;
        if (noise) randomize_inputs();
      end
    end
    check({tag, "_latency"}, 64'(n), 64'(n_exp));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(n_exp));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    check({tag, "_product"}, 64'(bus.product), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    check({tag, "_idle_after"}, 64'(bus.busy), 64'(0));
    bus.start = 1'b0;
  endtask
  initial begin
    int seen;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_product", 64'(bus.product), 64'(0));
    rst = 1'b0;
    run_op("u_3x5", 1'b0, 16'd3, 16'd5, 1'b0);
    run_op("u_max", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("s_m3x5", 1'b1, 16'hFFFD, 16'd5, 1'b0);
    run_op("s_min_min", 1'b1, 16'h8000, 16'h8000, 1'b0);
    run_op("s_min_x1", 1'b1, 16'h8000, 16'h0001, 1'b0);
    run_op("u_b1", 1'b0, 16'h1234, 16'h0001, 1'b0);
    run_op("s_b0", 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    run_op("s_a0", 1'b1, 16'h0000, 16'h8001, 1'b0);
    run_op("u_noise", 1'b0, 16'h00C3, 16'h0A5A, 1'b1);
    run_op("u_pre_rst", 1'b0, 16'h1234, 16'h5678, 1'b0);
    bus.start = 1'b1;
    bus.a = 16'h4321;
    bus.b = 16'h8765;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_product", 64'(bus.product), 64'(0));
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("rst_no_done", 64'(seen), 64'(0));
    run_op("after_rst", 1'b1, 16'h7FFF, 16'h8000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic sm;
      logic [W-1:0] ra, rb;
      sm = 1'($urandom);
      ra = W'($urandom);
      rb = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_op($sformatf("rand%0d", i), sm, ra, rb, i % 5 == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
